// File: rtl/w5300_reset_sequencer.sv
// Multi-channel W5300 RESET# sequencer: per channel, a low pulse then a PLL settle wait before ready.
// Optional macro RESET_EVENT_COUNT_EN enables the saturating accepted-trigger counter on reset_count.
module w5300_reset_sequencer #(
    parameter int NUM_CH            = 1,
    parameter int PULSE_CYCLES      = 50,
    parameter int READY_WAIT_CYCLES = 200
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NUM_CH-1:0]     trigger_reset,
    output logic [NUM_CH-1:0]     w5300_resetl,
    output logic [NUM_CH-1:0]     ready,
    output logic                  busy,
    output logic [7:0]            reset_count,
    output logic [2*NUM_CH-1:0]   state_dbg
);

    localparam int MAX_CYC = (PULSE_CYCLES > READY_WAIT_CYCLES) ? PULSE_CYCLES : READY_WAIT_CYCLES;
    localparam int CNT_W   = (MAX_CYC < 1) ? 1 : $clog2(MAX_CYC + 1);

    localparam logic [CNT_W-1:0] PULSE_LAST = CNT_W'(PULSE_CYCLES - 1);
    localparam logic [CNT_W-1:0] WAIT_LAST  =
        CNT_W'((READY_WAIT_CYCLES > 0) ? READY_WAIT_CYCLES - 1 : 0);

    typedef enum logic [1:0] {
        ST_ASSERT = 2'd0,
        ST_WAIT   = 2'd1,
        ST_IDLE   = 2'd2
    } state_e;

    // A zero settle time skips WAIT entirely.
    localparam state_e PULSE_NEXT = (READY_WAIT_CYCLES == 0) ? ST_IDLE : ST_WAIT;

    state_e           state_q [NUM_CH];
    state_e           state_d [NUM_CH];
    logic [CNT_W-1:0] cnt_q   [NUM_CH];
    logic [CNT_W-1:0] cnt_d   [NUM_CH];

    always_comb begin
        for (int ch = 0; ch < NUM_CH; ch++) begin
            state_d[ch] = state_q[ch];
            cnt_d[ch]   = cnt_q[ch];
            case (state_q[ch])
                ST_ASSERT: begin
                    // Holding trigger keeps the count pinned, stretching the pulse.
                    if (trigger_reset[ch]) begin
                        cnt_d[ch] = '0;
                    end else if (cnt_q[ch] == PULSE_LAST) begin
                        state_d[ch] = PULSE_NEXT;
                        cnt_d[ch]   = '0;
                    end else begin
                        cnt_d[ch] = cnt_q[ch] + 1'b1;
                    end
                end
                ST_WAIT: begin
                    if (trigger_reset[ch]) begin
                        state_d[ch] = ST_ASSERT;
                        cnt_d[ch]   = '0;
                    end else if (cnt_q[ch] == WAIT_LAST) begin
                        state_d[ch] = ST_IDLE;
                        cnt_d[ch]   = '0;
                    end else begin
                        cnt_d[ch] = cnt_q[ch] + 1'b1;
                    end
                end
                ST_IDLE: begin
                    if (trigger_reset[ch]) begin
                        state_d[ch] = ST_ASSERT;
                        cnt_d[ch]   = '0;
                    end
                end
                default: begin
                    state_d[ch] = ST_ASSERT;
                    cnt_d[ch]   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        for (int ch = 0; ch < NUM_CH; ch++) begin
            if (reset) begin
                state_q[ch] <= ST_ASSERT;
                cnt_q[ch]   <= '0;
            end else begin
                state_q[ch] <= state_d[ch];
                cnt_q[ch]   <= cnt_d[ch];
            end
        end
    end

    // Outputs decode only the state flops, so trigger never reaches a pin combinationally.
    always_comb begin
        busy = 1'b0;
        for (int ch = 0; ch < NUM_CH; ch++) begin
            w5300_resetl[ch]       = (state_q[ch] != ST_ASSERT);
            ready[ch]              = (state_q[ch] == ST_IDLE);
            busy                   = busy | (state_q[ch] != ST_IDLE);
            state_dbg[2*ch +: 2]   = state_q[ch];
        end
    end

`ifdef RESET_EVENT_COUNT_EN
    logic       trig_accept;
    logic [7:0] evt_cnt_q;

    // Only restarts from WAIT/IDLE count; stretching an active pulse does not.
    always_comb begin
        trig_accept = 1'b0;
        for (int ch = 0; ch < NUM_CH; ch++) begin
            if (trigger_reset[ch] && (state_q[ch] != ST_ASSERT)) begin
                trig_accept = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            evt_cnt_q <= 8'h00;
        end else if (trig_accept && (evt_cnt_q != 8'hFF)) begin
            evt_cnt_q <= evt_cnt_q + 8'h01;
        end
    end

    assign reset_count = evt_cnt_q;
`else
    assign reset_count = 8'h00;
`endif

endmodule

// File: tb/tb_w5300_reset_sequencer.sv
// Self-checking bench for w5300_reset_sequencer (NUM_CH=2, PULSE=4, WAIT=6).
// Expected per-cycle {resetl, ready, busy} vectors are queued up front and drained as the DUT runs.
module tb_w5300_reset_sequencer;

  localparam int NUM_CH = 2;
`ifdef RESET_EVENT_COUNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  logic              clk;
  logic              reset;
  logic [NUM_CH-1:0] trigger_reset;
  logic [NUM_CH-1:0] w5300_resetl;
  logic [NUM_CH-1:0] ready;
  logic              busy;
  logic [7:0]        reset_count;
  logic [2*NUM_CH-1:0] state_dbg;

  int tests_run;
  int tests_failed;
  logic [4:0] exp_q[$];
  logic [4:0] exp_v;
  logic [4:0] act_v;
  logic [7:0] exp_cnt;

  w5300_reset_sequencer #(
    .NUM_CH(NUM_CH),
    .PULSE_CYCLES(4),
    .READY_WAIT_CYCLES(6)
  ) dut (
    .clk(clk),
    .reset(reset),
    .trigger_reset(trigger_reset),
    .w5300_resetl(w5300_resetl),
    .ready(ready),
    .busy(busy),
    .reset_count(reset_count),
    .state_dbg(state_dbg)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_n(input logic [4:0] v, input int n);
    for (int i = 0; i < n; i++) exp_q.push_back(v);
  endtask

  // vector layout: {resetl[1:0], ready[1:0], busy}
  task automatic test_reset();
    reset = 1'b1;
    trigger_reset = '0;
    push_n(5'b00_00_1, 3);
    for (int i = 0; i < 3; i++) begin
      step();
      exp_v = exp_q.pop_front();
      act_v = {w5300_resetl, ready, busy};
      tests_run++;
      if (act_v !== exp_v) begin
        tests_failed++;
        $display("FAIL reset_hold cycle %0d: got %b expected %b", i, act_v, exp_v);
      end
    end
    tests_run++;
    if (reset_count !== 8'h00) begin
      tests_failed++;
      $display("FAIL reset_count_por: got %0d expected 0", reset_count);
    end
    reset = 1'b0;
    push_n(5'b00_00_1, 3);
    push_n(5'b11_00_1, 6);
    push_n(5'b11_11_0, 3);
    for (int k = 0; exp_q.size() > 0; k++) begin
      step();
      exp_v = exp_q.pop_front();
      act_v = {w5300_resetl, ready, busy};
      tests_run++;
      if (act_v !== exp_v) begin
        tests_failed++;
        $display("FAIL power_on cycle %0d: got %b expected %b", k, act_v, exp_v);
      end
    end
  endtask

  task automatic test_single_trigger();
    push_n(5'b10_10_1, 4);
    push_n(5'b11_10_1, 6);
    push_n(5'b11_11_0, 2);
    for (int k = 0; exp_q.size() > 0; k++) begin
      trigger_reset = (k == 0) ? 2'b01 : 2'b00;
      step();
      exp_v = exp_q.pop_front();
      act_v = {w5300_resetl, ready, busy};
      tests_run++;
      if (act_v !== exp_v) begin
        tests_failed++;
        $display("FAIL single_trigger cycle %0d: got %b expected %b", k, act_v, exp_v);
      end
    end
    exp_cnt = CNT_EN ? 8'd1 : 8'd0;
    tests_run++;
    if (reset_count !== exp_cnt) begin
      tests_failed++;
      $display("FAIL count_single: got %0d expected %0d", reset_count, exp_cnt);
    end
  endtask

  task automatic test_held_trigger();
    push_n(5'b01_01_1, 13);
    push_n(5'b11_01_1, 6);
    push_n(5'b11_11_0, 2);
    for (int k = 0; exp_q.size() > 0; k++) begin
      trigger_reset = (k < 10) ? 2'b10 : 2'b00;
      step();
      exp_v = exp_q.pop_front();
      act_v = {w5300_resetl, ready, busy};
      tests_run++;
      if (act_v !== exp_v) begin
        tests_failed++;
        $display("FAIL held_trigger cycle %0d: got %b expected %b", k, act_v, exp_v);
      end
    end
    exp_cnt = CNT_EN ? 8'd2 : 8'd0;
    tests_run++;
    if (reset_count !== exp_cnt) begin
      tests_failed++;
      $display("FAIL count_held: got %0d expected %0d", reset_count, exp_cnt);
    end
  endtask

  task automatic test_retrigger_wait();
    push_n(5'b10_10_1, 4);
    push_n(5'b11_10_1, 4);
    push_n(5'b10_10_1, 4);
    push_n(5'b11_10_1, 6);
    push_n(5'b11_11_0, 1);
    for (int k = 0; exp_q.size() > 0; k++) begin
      trigger_reset = (k == 0 || k == 8) ? 2'b01 : 2'b00;
      step();
      exp_v = exp_q.pop_front();
      act_v = {w5300_resetl, ready, busy};
      tests_run++;
      if (act_v !== exp_v) begin
        tests_failed++;
        $display("FAIL retrigger_wait cycle %0d: got %b expected %b", k, act_v, exp_v);
      end
    end
    exp_cnt = CNT_EN ? 8'd4 : 8'd0;
    tests_run++;
    if (reset_count !== exp_cnt) begin
      tests_failed++;
      $display("FAIL count_retrigger: got %0d expected %0d", reset_count, exp_cnt);
    end
  endtask

  task automatic test_reset_mid();
    push_n(5'b10_10_1, 4);
    push_n(5'b11_10_1, 2);
    push_n(5'b00_00_1, 4);
    push_n(5'b11_00_1, 6);
    push_n(5'b11_11_0, 1);
    for (int k = 0; exp_q.size() > 0; k++) begin
      trigger_reset = (k == 0) ? 2'b01 : 2'b00;
      reset = (k == 6);
      step();
      exp_v = exp_q.pop_front();
      act_v = {w5300_resetl, ready, busy};
      tests_run++;
      if (act_v !== exp_v) begin
        tests_failed++;
        $display("FAIL reset_mid cycle %0d: got %b expected %b", k, act_v, exp_v);
      end
    end
    reset = 1'b0;
    tests_run++;
    if (reset_count !== 8'h00) begin
      tests_failed++;
      $display("FAIL count_after_reset: got %0d expected 0", reset_count);
    end
  endtask

  task automatic test_event_count();
    for (int n = 0; n < 3; n++) begin
      trigger_reset = 2'b01;
      step();
      trigger_reset = 2'b00;
      repeat (11) step();
    end
    trigger_reset = 2'b11;
    step();
    trigger_reset = 2'b00;
    repeat (11) step();
    exp_cnt = CNT_EN ? 8'd4 : 8'd0;
    tests_run++;
    if (reset_count !== exp_cnt) begin
      tests_failed++;
      $display("FAIL count_four: got %0d expected %0d", reset_count, exp_cnt);
    end
    // each retrigger lands in WAIT, so every one is accepted
    for (int n = 0; n < 300; n++) begin
      trigger_reset = ($urandom_range(0, 1) == 0) ? 2'b01 : 2'b11;
      step();
      trigger_reset = 2'b00;
      repeat (4) step();
    end
    repeat (12) step();
    exp_cnt = CNT_EN ? 8'd255 : 8'd0;
    tests_run++;
    if (reset_count !== exp_cnt) begin
      tests_failed++;
      $display("FAIL count_saturate: got %0d expected %0d", reset_count, exp_cnt);
    end
    push_n(5'b11_11_0, 1);
    exp_v = exp_q.pop_front();
    act_v = {w5300_resetl, ready, busy};
    tests_run++;
    if (act_v !== exp_v) begin
      tests_failed++;
      $display("FAIL idle_after_burst: got %b expected %b", act_v, exp_v);
    end
  endtask

  initial begin
    tests_run = 0;
    tests_failed = 0;
    reset = 1'b1;
    trigger_reset = '0;
    test_reset();
    test_single_trigger();
    test_held_trigger();
    test_retrigger_wait();
    test_reset_mid();
    test_event_count();
    // final report
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
